fir_tap_sequencer: RTL and testbench

- Control and datapath stage placed directly upstream of the FIR accumulator register.
- Accepts input samples over a valid/ready handshake and keeps the last TAPS samples in a circular delay line.
- For each sample it sequences TAPS multiply-accumulate cycles. It drives the accumulator register's d_in, load and clear, and reads back its q_out.
- It presents the finished filter output over a valid/ready handshake.

---
 rtl/fir_tap_sequencer.sv | 127 ++++++++++++
 tb/tb_fir_tap_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - FIR tap sequencer driving an external accumulator register (option: FIR_SAT_EN)
module fir_tap_sequencer #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  localparam int AW    = $clog2(TAPS),
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic signed [ACC_W-1:0]  acc_d,
  output logic                     acc_load,
  output logic                     acc_clear,
  input  logic signed [ACC_W-1:0]  acc_q,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     out_ready
);

  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, MAC, DONE} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  dline [TAPS];
  logic [AW-1:0]             wp;
  logic [AW-1:0]             k;
  logic [AW-1:0]             rd_idx;
  logic signed [DATA_W-1:0]  sample;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   result;

  // Held low during reset so nothing is accepted before the delay line is cleared.
  assign in_ready  = rst && (state == IDLE);
  assign coef_addr = k;

  // Newest-first read index (wp-1-k) mod TAPS, wrapped by compare so odd TAPS works.
  always_comb begin
    rd_idx = '0;
    if (wp > k) rd_idx = wp - k - AW'(1);
    else        rd_idx = LAST - k + wp;
  end

  // Signed product sign-extended into the accumulator width; acc_d only live during MAC.
  always_comb begin
    sample   = dline[rd_idx];
    prod     = PW'(sample) * PW'(coef_data);
    prod_ext = ACC_W'(prod);
    acc_d    = (state == MAC) ? acc_q + prod_ext : '0;
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
  logic signed [ACC_W-1:0] shifted;

  // Rescale the Q1.(COEF_W-1) product sum back to sample range and clamp.
  always_comb begin
    shifted = acc_q >>> (COEF_W - 1);
    if (shifted > SAT_MAX)      result = SAT_MAX;
    else if (shifted < SAT_MIN) result = SAT_MIN;
    else                        result = shifted;
  end
`else
  // Full-precision output straight from the accumulator.
  always_comb begin
    result = acc_q;
  end
`endif

  assign out_data = out_valid ? result : '0;

  // Sequencer FSM: capture sample, clear accumulator, TAPS MAC cycles, hold result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wp        <= '0;
      k         <= '0;
      acc_load  <= 1'b0;
      acc_clear <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) dline[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dline[wp] <= in_data;
            wp        <= (wp == LAST) ? '0 : wp + AW'(1);
            acc_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          acc_clear <= 1'b0;
          acc_load  <= 1'b1;
          k         <= '0;
          state     <= MAC;
        end
        MAC: begin
          if (k == LAST) begin
            k         <= '0;
            acc_load  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + AW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - directed self-checking bench for fir_tap_sequencer
module tb_fir_tap_sequencer;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic signed [34:0] acc_d;
  logic               acc_load;
  logic               acc_clear;
  logic signed [34:0] acc_q;
  logic               out_valid;
  logic signed [34:0] out_data;
  logic               out_ready;

  int vectors    = 0;
  int miscompares = 0;

  fir_tap_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .acc_d     (acc_d),
    .acc_load  (acc_load),
    .acc_clear (acc_clear),
    .acc_q     (acc_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient ROM: coef[k] = k+1.
  assign coef_data = {13'd0, coef_addr} + 16'sd1;

  // External accumulator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           acc_q <= '0;
    else if (acc_clear) acc_q <= '0;
    else if (acc_load)  acc_q <= acc_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] d, input logic signed [63:0] exp, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 30 && !out_valid; i++) tick();
    check({tag, "_valid"}, 64'(out_valid), 64'sd1);
    check(tag, 64'(out_data), exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();

    check("rst_in_ready",  64'(in_ready),  64'sd0);
    check("rst_out_valid", 64'(out_valid), 64'sd0);
    check("rst_acc_load",  64'(acc_load),  64'sd0);
    check("rst_acc_clear", 64'(acc_clear), 64'sd0);
    check("rst_coef_addr", 64'(coef_addr), 64'sd0);
    check("rst_acc_d",     64'(acc_d),     64'sd0);

    rst = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'sd1);

    // Latency: accept 1 at edge N.
    in_valid = 1'b1;
    in_data  = 16'sd1;
    tick();
    in_valid = 1'b0;
    check("lat_clear",    64'(acc_clear), 64'sd1);
    check("lat_load_c",   64'(acc_load),  64'sd0);
    check("lat_in_ready", 64'(in_ready),  64'sd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("lat_load",  64'(acc_load),  64'sd1);
      check("lat_addr",  64'(coef_addr), 64'(i));
      check("lat_clr_m", 64'(acc_clear), 64'sd0);
    end
    tick();
    check("lat_out_valid", 64'(out_valid), 64'sd1);
    check("lat_out_data",  64'(out_data),  64'sd1);
    check("lat_load_d",    64'(acc_load),  64'sd0);
    check("lat_acc_d_d",   64'(acc_d),     64'sd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lat_out_drop", 64'(out_valid), 64'sd0);

    // Impulse tail: eight zeros after the leading 1.
    for (int i = 0; i < 8; i++) send(16'sd0, (i < 7) ? 64'(i + 2) : 64'sd0, "impulse");

    // Step response.
    for (int i = 0; i < 8; i++) send(16'sd1, 64'((i + 1) * (i + 2) / 2), "step");

    // Backpressure with a pending input sample.
    in_valid = 1'b1;
    in_data  = 16'sd1;
    tick();
    in_data  = 16'sd0;
    for (int i = 0; i < 30 && !out_valid; i++) tick();
    check("bp_first", 64'(out_data), 64'sd36);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",    64'(out_valid), 64'sd1);
      check("bp_data",     64'(out_data),  64'sd36);
      check("bp_in_ready", 64'(in_ready),  64'sd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", 64'(in_ready),  64'sd1);
    check("bp_out_drop",   64'(out_valid), 64'sd0);
    tick();
    in_valid = 1'b0;
    check("bp_accept_clear", 64'(acc_clear), 64'sd1);
    for (int i = 0; i < 30 && !out_valid; i++) tick();
    check("bp_next_valid", 64'(out_valid), 64'sd1);
    check("bp_next_data",  64'(out_data),  64'sd35);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of MAC at k=3.
    in_valid = 1'b1;
    in_data  = 16'sd5;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("mid_addr", 64'(coef_addr), 64'sd3);
    rst = 1'b0;
    #1;
    check("mid_out_valid", 64'(out_valid), 64'sd0);
    check("mid_acc_load",  64'(acc_load),  64'sd0);
    check("mid_acc_clear", 64'(acc_clear), 64'sd0);
    check("mid_in_ready",  64'(in_ready),  64'sd0);
    check("mid_acc_d",     64'(acc_d),     64'sd0);
    tick();
    rst = 1'b1;
    #1;
    check("mid_release_ready", 64'(in_ready), 64'sd1);
    send(16'sd1, 64'sd1, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
